// File: rtl/fp_norm_pack.sv
// Purpose: post-normalise, round and pack the FP add/sub raw sum into IEEE-754 binary32 with overflow/underflow flags.
// Latency: 2 cycles from accept to out_valid; one result per cycle sustained, order preserved.
// Backpressure: valid/ready on both sides; a stalled output holds steady and stage 1 refills only when stage 2 can advance.
module fp_norm_pack #(
    parameter bit ROUND_EN = 1'b1,
    parameter bit FLUSH_UF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_i,
    input  logic [7:0]  exp_i,
    input  logic [24:0] mant_i,
    input  logic [7:0]  sfr_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result_o,
    output logic        ovf_o,
    output logic        unf_o
);

    // Normalisation action selected by the leading-one shift code
    typedef enum logic [1:0] {
        K_ZERO = 2'd0,
        K_NOSH = 2'd1,
        K_RSH  = 2'd2,
        K_LSH  = 2'd3
    } kind_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        kind_e       kind;
        logic [4:0]  lsh;
    } s1_t;

    logic        s1_valid;
    logic        s1_advance;
    s1_t         s1_q;
    s1_t         s1_d;

    kind_e       dec_kind;
    logic [4:0]  dec_lsh;

    logic [22:0]       frac;
    logic signed [9:0] exp_adj;
    logic              rnd_up;
    logic [23:0]       rsum;
    logic              is_zero;
    logic [31:0]       nxt_res;
    logic              nxt_ovf;
    logic              nxt_unf;

    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;

    // Decode the shift code; unreachable codes fall back to a zero result
    always_comb begin
        dec_kind = K_ZERO;
        dec_lsh  = 5'd0;
        if (sfr_i == 8'h01) begin
            dec_kind = K_RSH;
        end else if (sfr_i == 8'h00) begin
            dec_kind = K_NOSH;
        end else if ((sfr_i >= 8'hE8) && (sfr_i <= 8'hFE)) begin
            dec_kind = K_LSH;
            // L = -sfr - 1 is the bitwise inverse of the code; 1..23 fits in 5 bits
            dec_lsh  = ~sfr_i[4:0];
        end
    end

    // Stage-1 payload assembled from the input operand and decoded shift
    always_comb begin
        s1_d.sign = sign_i;
        s1_d.exp  = exp_i;
        s1_d.mant = mant_i;
        s1_d.kind = dec_kind;
        s1_d.lsh  = dec_lsh;
    end

    // Stage 1 register: load whenever the slot is free or draining into stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage 2 datapath: shift, round, adjust exponent in 10-bit signed, pack
    always_comb begin
        frac    = 23'd0;
        exp_adj = $signed({2'b00, s1_q.exp});
        rnd_up  = 1'b0;
        rsum    = 24'd0;
        is_zero = 1'b0;
        nxt_res = 32'd0;
        nxt_ovf = 1'b0;
        nxt_unf = 1'b0;

        case (s1_q.kind)
            K_RSH: begin
                // One dropped bit is always an exact half: round to even
                rnd_up = ROUND_EN & s1_q.mant[0] & s1_q.mant[1];
                rsum   = {1'b0, s1_q.mant[23:1]} + {23'd0, rnd_up};
                if (rsum[23] && s1_q.mant[24]) begin
                    // Rounding carried past the hidden bit: mantissa becomes 1.0
                    frac    = 23'd0;
                    exp_adj = exp_adj + 10'sd2;
                end else begin
                    frac    = rsum[22:0];
                    exp_adj = exp_adj + 10'sd1;
                end
            end
            K_NOSH: begin
                frac = s1_q.mant[22:0];
            end
            K_LSH: begin
                // Left shift is exact; bits above the hidden position fall off
                frac    = s1_q.mant[22:0] << s1_q.lsh;
                exp_adj = exp_adj - $signed({5'd0, s1_q.lsh});
            end
            default: begin
                is_zero = 1'b1;
            end
        endcase

        if (is_zero) begin
            nxt_res = {s1_q.sign, 31'd0};
        end else if (exp_adj >= 10'sd255) begin
            nxt_res = {s1_q.sign, 8'hFF, 23'd0};
            nxt_ovf = 1'b1;
        end else if (exp_adj <= 10'sd0) begin
            // No denormal support: underflow flushes to signed zero
            nxt_res = {s1_q.sign, 31'd0};
            nxt_unf = FLUSH_UF;
        end else begin
            nxt_res = {s1_q.sign, exp_adj[7:0], frac};
        end
    end

    // Stage 2 register: outputs only move when downstream is not stalling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result_o  <= 32'd0;
            ovf_o     <= 1'b0;
            unf_o     <= 1'b0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result_o <= nxt_res;
                ovf_o    <= nxt_ovf;
                unf_o    <= nxt_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_pack.sv
module tb_fp_norm_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sign_i = 1'b0;
    logic [7:0]  exp_i = 8'd0;
    logic [24:0] mant_i = 25'd0;
    logic [7:0]  sfr_i = 8'd0;

    logic        r_in_ready, r_out_valid, r_ovf, r_unf;
    logic [31:0] r_res;
    logic        t_in_ready, t_out_valid, t_ovf, t_unf;
    logic [31:0] t_res;

    fp_norm_pack #(.ROUND_EN(1'b1), .FLUSH_UF(1'b1)) u_rne (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
        .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i), .sfr_i(sfr_i),
        .out_valid(r_out_valid), .out_ready(out_ready), .result_o(r_res),
        .ovf_o(r_ovf), .unf_o(r_unf)
    );

    fp_norm_pack #(.ROUND_EN(1'b0), .FLUSH_UF(1'b1)) u_trn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
        .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i), .sfr_i(sfr_i),
        .out_valid(t_out_valid), .out_ready(out_ready), .result_o(t_res),
        .ovf_o(t_ovf), .unf_o(t_unf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [33:0] r;
        logic [33:0] t;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    bit   rand_rdy = 1'b0;

    // Reference: plain integer arithmetic on the mantissa value; returns {ovf, unf, word}
    function automatic logic [33:0] model(input logic s, input logic [7:0] e8,
                                          input logic [24:0] m, input logic [7:0] sfr,
                                          input bit rnd_en);
        longint q;
        int     e;
        int     l;
        logic [22:0] f;
        if (sfr == 8'h01) begin
            q = longint'(m) / 2;
            e = int'(e8) + 1;
            if (rnd_en && (m % 2 == 1) && (q % 2 == 1)) q = q + 1;
            if (q >= 64'd16777216) begin
                q = q / 2;
                e = e + 1;
            end
        end else if (sfr == 8'h00) begin
            q = longint'(m);
            e = int'(e8);
        end else if (sfr >= 8'hE8 && sfr <= 8'hFE) begin
            l = 255 - int'(sfr);
            q = longint'(m) * (longint'(1) << l);
            e = int'(e8) - l;
        end else begin
            return {2'b00, s, 31'd0};
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, s, 31'd0};
        f = 23'(q % 64'd8388608);
        return {2'b00, s, 8'(e), f};
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: settle inputs, score any output/input transfer, advance to next falling edge
    task automatic tick(output bit acc);
        exp_t e;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = 1'b0;
        if (r_out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_out", {33'd0, r_out_valid}, 34'd0);
            end else begin
                e = sbq.pop_front();
                check("rne_out", {r_ovf, r_unf, r_res}, e.r);
                check("trn_out", {t_ovf, t_unf, t_res}, e.t);
                check("trn_valid", {33'd0, t_out_valid}, 34'd1);
            end
        end
        if (in_valid && r_in_ready) begin
            sbq.push_back(cur);
            acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] m,
                         input logic [7:0] sfr, input logic [33:0] er, input logic [33:0] et);
        in_valid = 1'b1;
        sign_i   = s;
        exp_i    = e;
        mant_i   = m;
        sfr_i    = sfr;
        cur      = '{r: er, t: et};
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [7:0] sfr, input logic [33:0] er, input logic [33:0] et);
        bit acc;
        int n;
        drive(s, e, m, sfr, er, et);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            tick(acc);
            n++;
        end
        if (!acc) check("accept_timeout", {33'd0, acc}, 34'd1);
    endtask

    task automatic send_rand();
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [7:0]  sfr;
        int          k;
        s = 1'($urandom);
        e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 255));
        case ($urandom_range(0, 5))
            0, 1: begin
                sfr = 8'h01;
                m   = {1'b1, 24'($urandom)};
            end
            2: begin
                sfr = 8'h00;
                m   = {2'b01, 23'($urandom)};
            end
            3, 4: begin
                k   = $urandom_range(0, 22);
                sfr = 8'(k - 24);
                m   = (25'd1 << k) | (25'($urandom) & ((25'd1 << k) - 25'd1));
            end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    sfr = 8'hFF;
                    m   = 25'd0;
                end else begin
                    sfr = 8'($urandom_range(2, 231));
                    m   = 25'($urandom);
                end
            end
        endcase
        send(s, e, m, sfr, model(s, e, m, sfr, 1'b1), model(s, e, m, sfr, 1'b0));
    endtask

    task automatic drain();
        bit acc;
        int n;
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sbq.size() != 0 || r_out_valid) && n < 50) begin
            tick(acc);
            n++;
        end
        check("drain_empty", 34'(sbq.size()), 34'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        logic [33:0] hold_r;

        // Reset state
        #1;
        check("rst_out_valid", {33'd0, r_out_valid}, 34'd0);
        check("rst_outputs", {r_ovf, r_unf, r_res}, 34'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {33'd0, r_in_ready}, 34'd1);
        @(negedge clk);

        // Test 1 with latency observation: accept, one cycle in stage 1, then visible
        drive(1'b0, 8'h80, 25'h1800000, 8'h01, {2'b00, 32'h40C00000}, {2'b00, 32'h40C00000});
        tick(acc);
        check("lat_accept", {33'd0, acc}, 34'd1);
        in_valid = 1'b0;
        #1;
        check("lat_stage1", {33'd0, r_out_valid}, 34'd0);
        tick(acc);
        check("lat_out", {33'd0, r_out_valid}, 34'd1);
        tick(acc);

        // Directed cases back to back
        send(1'b0, 8'h80, 25'h0400000, 8'hFE, {2'b00, 32'h3F800000}, {2'b00, 32'h3F800000});
        send(1'b1, 8'h55, 25'h0000000, 8'hFF, {2'b00, 32'h80000000}, {2'b00, 32'h80000000});
        send(1'b0, 8'h7F, 25'h1FFFFFF, 8'h01, {2'b00, 32'h40800000}, {2'b00, 32'h407FFFFF});
        send(1'b0, 8'hFE, 25'h1000000, 8'h01, {2'b10, 32'h7F800000}, {2'b10, 32'h7F800000});
        send(1'b0, 8'h03, 25'h0000001, 8'hE8, {2'b01, 32'h00000000}, {2'b01, 32'h00000000});
        send(1'b1, 8'hFF, 25'h0C00000, 8'h00, {2'b10, 32'hFF800000}, {2'b10, 32'hFF800000});
        send(1'b1, 8'h10, 25'h1234567, 8'h40, {2'b00, 32'h80000000}, {2'b00, 32'h80000000});
        drain();

        // Backpressure: two accepted, third blocked, output frozen for the stall
        out_ready = 1'b0;
        send(1'b0, 8'h80, 25'h1800000, 8'h01, {2'b00, 32'h40C00000}, {2'b00, 32'h40C00000});
        send(1'b0, 8'h80, 25'h0400000, 8'hFE, {2'b00, 32'h3F800000}, {2'b00, 32'h3F800000});
        drive(1'b1, 8'h7F, 25'h1FFFFFF, 8'h01, {2'b00, 32'hC0800000}, {2'b00, 32'hC07FFFFF});
        #1;
        check("bp_in_ready", {33'd0, r_in_ready}, 34'd0);
        check("bp_out_valid", {33'd0, r_out_valid}, 34'd1);
        hold_r = {r_ovf, r_unf, r_res};
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("bp_no_accept", {33'd0, acc}, 34'd0);
            check("bp_hold", {r_ovf, r_unf, r_res}, hold_r);
            check("bp_hold_valid", {33'd0, r_out_valid}, 34'd1);
        end
        out_ready = 1'b1;
        send(1'b1, 8'h7F, 25'h1FFFFFF, 8'h01, {2'b00, 32'hC0800000}, {2'b00, 32'hC07FFFFF});
        drain();

        // Asynchronous reset with data in flight
        out_ready = 1'b0;
        send(1'b0, 8'h40, 25'h1000000, 8'h01, {2'b00, 32'h20800000}, {2'b00, 32'h20800000});
        send(1'b0, 8'h41, 25'h1000000, 8'h01, {2'b00, 32'h21000000}, {2'b00, 32'h21000000});
        in_valid = 1'b0;
        #2;
        check("pre_rst_valid", {33'd0, r_out_valid}, 34'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {33'd0, r_out_valid}, 34'd0);
        check("mid_rst_out", {r_ovf, r_unf, r_res}, 34'd0);
        check("mid_rst_ready", {33'd0, r_in_ready}, 34'd1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(acc);
        tick(acc);
        check("post_rst_idle", {33'd0, r_out_valid}, 34'd0);

        // Randomised traffic with random downstream stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                tick(acc);
            end else begin
                send_rand();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
